// File: rtl/sprite_motion_gen_if.sv
// Control and coordinate bundle between a sprite motion generator and its host.
// The host drives frame timing, launch values and control levels; the generator returns the object position and status.
interface sprite_motion_gen_if;
  logic        startOfFrame;
  logic        launch;
  logic [10:0] launchX;
  logic [10:0] launchY;
  logic [15:0] launchXspeed;
  logic [15:0] launchYspeed;
  logic        pause;
  logic        kill;
  logic        kickY;
  logic [10:0] topLeftX;
  logic [10:0] topLeftY;
  logic        active;
  logic [3:0]  hitEdge;
  logic [1:0]  state;

  modport master (
    output startOfFrame, launch, launchX, launchY, launchXspeed, launchYspeed,
           pause, kill, kickY,
    input  topLeftX, topLeftY, active, hitEdge, state
  );

  modport slave (
    input  startOfFrame, launch, launchX, launchY, launchXspeed, launchYspeed,
           pause, kill, kickY,
    output topLeftX, topLeftY, active, hitEdge, state
  );
endinterface

// File: rtl/sprite_motion_gen.sv
// Per-frame sprite trajectory generator: fixed-point position, speed with Y gravity,
// bounce/wrap/stop edges per axis, and a launch/delay/pause/kill control FSM.
module sprite_motion_gen #(
  parameter int FRAC_BITS    = 6,
  parameter int X_MIN        = 0,
  parameter int X_MAX        = 639,
  parameter int Y_MIN        = 0,
  parameter int Y_MAX        = 479,
  parameter int OBJ_W        = 64,
  parameter int OBJ_H        = 64,
  parameter int X_EDGE_MODE  = 0,
  parameter int Y_EDGE_MODE  = 0,
  parameter int Y_ACCEL      = 1,
  parameter int MAX_SPEED    = 512,
  parameter int LAUNCH_DELAY = 0
) (
  input logic clk,
  input logic reset,
  sprite_motion_gen_if.slave bus
);
  localparam int PW = 12 + FRAC_BITS;
  // Two guard bits so pos+speed and wrap arithmetic cannot overflow before the edge test.
  localparam int CW = PW + 2;

  localparam logic signed [CW-1:0] ONE_PX = CW'(1 << FRAC_BITS);
  localparam logic signed [CW-1:0] XL     = CW'(X_MIN * (1 << FRAC_BITS));
  localparam logic signed [CW-1:0] XH     = CW'((X_MAX - OBJ_W) * (1 << FRAC_BITS));
  localparam logic signed [CW-1:0] YL     = CW'(Y_MIN * (1 << FRAC_BITS));
  localparam logic signed [CW-1:0] YH     = CW'((Y_MAX - OBJ_H) * (1 << FRAC_BITS));
  localparam logic signed [CW-1:0] X_SPAN = XH - XL + ONE_PX;
  localparam logic signed [CW-1:0] Y_SPAN = YH - YL + ONE_PX;
  localparam logic signed [16:0]   MAX17  = 17'(MAX_SPEED);
  localparam logic signed [16:0]   ACC17  = 17'(Y_ACCEL);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ARMED = 2'd1, S_MOVING = 2'd2, S_PAUSED = 2'd3} state_t;

  typedef struct packed {
    logic signed [PW-1:0] pos;
    logic signed [15:0]   spd;
    logic                 hit_lo;
    logic                 hit_hi;
  } axis_t;

  function automatic logic signed [15:0] clamp_spd(input logic signed [16:0] v);
    if (v > MAX17)       return MAX17[15:0];
    else if (v < -MAX17) return 16'(-MAX17);
    else                 return v[15:0];
  endfunction

  function automatic axis_t edge_rule(
    input logic signed [CW-1:0] n,
    input logic signed [15:0]   spd,
    input logic signed [CW-1:0] lo,
    input logic signed [CW-1:0] hi,
    input logic signed [CW-1:0] span,
    input int                   mode
  );
    axis_t r;
    r.pos    = PW'(n);
    r.spd    = spd;
    r.hit_lo = 1'b0;
    r.hit_hi = 1'b0;
    if (n <= lo && spd < 16'sd0) begin
      r.hit_lo = 1'b1;
      case (mode)
        1:       r.pos = PW'(n + span);
        2:       begin r.pos = PW'(lo); r.spd = '0; end
        default: begin r.pos = PW'(lo); r.spd = -spd; end
      endcase
    end else if (n >= hi && spd > 16'sd0) begin
      r.hit_hi = 1'b1;
      case (mode)
        1:       r.pos = PW'(n - span);
        2:       begin r.pos = PW'(hi); r.spd = '0; end
        default: begin r.pos = PW'(hi); r.spd = -spd; end
      endcase
    end
    return r;
  endfunction

  state_t               r_state, w_state_next;
  logic signed [PW-1:0] r_pos_x, r_pos_y, w_pos_x_next, w_pos_y_next;
  logic signed [15:0]   r_spd_x, r_spd_y, w_spd_x_next, w_spd_y_next;
  logic [15:0]          r_delay_cnt, w_cnt_next;
  logic                 r_kick_d;
  logic [10:0]          r_tl_x, r_tl_y;
  logic [3:0]           r_hit, w_hit_next;

  logic signed [CW-1:0] w_nx, w_ny;
  axis_t                w_ax, w_ay;
  logic signed [15:0]   w_grav, w_launch_xs, w_launch_ys;
  logic                 w_kick_flip;

  assign w_nx        = CW'(r_pos_x) + CW'(r_spd_x);
  assign w_ny        = CW'(r_pos_y) + CW'(r_spd_y);
  assign w_ax        = edge_rule(w_nx, r_spd_x, XL, XH, X_SPAN, X_EDGE_MODE);
  assign w_ay        = edge_rule(w_ny, r_spd_y, YL, YH, Y_SPAN, Y_EDGE_MODE);
  assign w_grav      = clamp_spd(17'(r_spd_y) + ACC17);
  assign w_launch_xs = clamp_spd(17'($signed(bus.launchXspeed)));
  assign w_launch_ys = clamp_spd(17'($signed(bus.launchYspeed)));
  assign w_kick_flip = bus.kickY && !r_kick_d && (r_spd_y > 16'sd0);

  always_comb begin
    w_state_next = r_state;
    w_pos_x_next = r_pos_x;
    w_pos_y_next = r_pos_y;
    w_spd_x_next = r_spd_x;
    w_spd_y_next = r_spd_y;
    w_cnt_next   = r_delay_cnt;
    w_hit_next   = '0;
    if (bus.kill) begin
      w_state_next = S_IDLE;
      w_spd_x_next = '0;
      w_spd_y_next = '0;
    end else if (bus.launch) begin
      w_pos_x_next = PW'({bus.launchX, {FRAC_BITS{1'b0}}});
      w_pos_y_next = PW'({bus.launchY, {FRAC_BITS{1'b0}}});
      w_spd_x_next = w_launch_xs;
      w_spd_y_next = w_launch_ys;
      w_cnt_next   = '0;
      w_state_next = (LAUNCH_DELAY == 0) ? S_MOVING : S_ARMED;
    end else begin
      case (r_state)
        S_ARMED: begin
          if (bus.startOfFrame) begin
            w_cnt_next = r_delay_cnt + 16'd1;
            if (w_cnt_next == 16'(LAUNCH_DELAY)) w_state_next = S_MOVING;
          end
        end
        S_MOVING: begin
          if (bus.pause) w_state_next = S_PAUSED;
          if (bus.startOfFrame) begin
            w_pos_x_next = w_ax.pos;
            w_spd_x_next = w_ax.spd;
            w_pos_y_next = w_ay.pos;
            w_hit_next   = {w_ay.hit_lo, w_ay.hit_hi, w_ax.hit_lo, w_ax.hit_hi};
            // A kick overrides both the Y edge speed change and gravity on that frame.
            if (w_kick_flip)                      w_spd_y_next = -r_spd_y;
            else if (w_ay.hit_lo || w_ay.hit_hi)  w_spd_y_next = w_ay.spd;
            else                                  w_spd_y_next = w_grav;
          end else if (w_kick_flip) begin
            w_spd_y_next = -r_spd_y;
          end
        end
        S_PAUSED: begin
          if (!bus.pause) w_state_next = S_MOVING;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_pos_x     <= '0;
      r_pos_y     <= '0;
      r_spd_x     <= '0;
      r_spd_y     <= '0;
      r_delay_cnt <= '0;
      r_kick_d    <= 1'b0;
      r_tl_x      <= '0;
      r_tl_y      <= '0;
      r_hit       <= '0;
    end else begin
      r_state     <= w_state_next;
      r_pos_x     <= w_pos_x_next;
      r_pos_y     <= w_pos_y_next;
      r_spd_x     <= w_spd_x_next;
      r_spd_y     <= w_spd_y_next;
      r_delay_cnt <= w_cnt_next;
      r_kick_d    <= bus.kickY;
      // Pixel outputs come from the next position so they land with the frame update.
      r_tl_x      <= w_pos_x_next[FRAC_BITS+10:FRAC_BITS];
      r_tl_y      <= w_pos_y_next[FRAC_BITS+10:FRAC_BITS];
      r_hit       <= w_hit_next;
    end
  end

  assign bus.topLeftX = r_tl_x;
  assign bus.topLeftY = r_tl_y;
  assign bus.active   = r_state[1];
  assign bus.hitEdge  = r_hit;
  assign bus.state    = r_state;
endmodule

// File: tb/tb_sprite_motion_gen.sv
// Bench for sprite_motion_gen: four parameter variants share one stimulus stream and are
// checked every cycle against an integer trajectory model, plus hand-computed spot values.
module tb_sprite_motion_gen;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        sof = 1'b0, launch = 1'b0, pause = 1'b0, kill = 1'b0, kick = 1'b0;
  logic [10:0] lx = '0, ly = '0;
  logic [15:0] lxs = '0, lys = '0;

  logic [10:0] o_tlx [4];
  logic [10:0] o_tly [4];
  logic        o_act [4];
  logic [3:0]  o_hit [4];
  logic [1:0]  o_st  [4];

  sprite_motion_gen_if ifs [4] ();

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_dut
      assign ifs[gi].startOfFrame = sof;
      assign ifs[gi].launch       = launch;
      assign ifs[gi].launchX      = lx;
      assign ifs[gi].launchY      = ly;
      assign ifs[gi].launchXspeed = lxs;
      assign ifs[gi].launchYspeed = lys;
      assign ifs[gi].pause        = pause;
      assign ifs[gi].kill         = kill;
      assign ifs[gi].kickY        = kick;
      sprite_motion_gen #(
        .X_EDGE_MODE (gi == 1 ? 1 : (gi == 2 ? 2 : 0)),
        .Y_EDGE_MODE (gi == 2 ? 2 : 0),
        .LAUNCH_DELAY(gi == 3 ? 2 : 0)
      ) u_dut (
        .clk  (clk),
        .reset(rst),
        .bus  (ifs[gi])
      );
      assign o_tlx[gi] = ifs[gi].topLeftX;
      assign o_tly[gi] = ifs[gi].topLeftY;
      assign o_act[gi] = ifs[gi].active;
      assign o_hit[gi] = ifs[gi].hitEdge;
      assign o_st[gi]  = ifs[gi].state;
    end
  endgenerate

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Trajectory model: screen 640x480, object 64x64, 1/64 pixel units, gravity +1, |speed| <= 512.
  localparam int XH = 575 * 64;
  localparam int YH = 415 * 64;

  function automatic int xmode(input int k); return (k == 1) ? 1 : (k == 2) ? 2 : 0; endfunction
  function automatic int ymode(input int k); return (k == 2) ? 2 : 0; endfunction
  function automatic int delay(input int k); return (k == 3) ? 2 : 0; endfunction
  function automatic int clampi(input int v); return (v > 512) ? 512 : (v < -512) ? -512 : v; endfunction

  function automatic void axis(input int n, input int v, input int hi, input int mode,
                               output int p, output int nv, output bit lo_hit, output bit hi_hit);
    p = n; nv = v; lo_hit = 0; hi_hit = 0;
    if (n <= 0 && v < 0) begin
      lo_hit = 1;
      if (mode == 1)      p = n + hi + 64;
      else begin p = 0;   nv = (mode == 2) ? 0 : -v; end
    end else if (n >= hi && v > 0) begin
      hi_hit = 1;
      if (mode == 1)      p = n - (hi + 64);
      else begin p = hi;  nv = (mode == 2) ? 0 : -v; end
    end
  endfunction

  int m_px[4], m_py[4], m_vx[4], m_vy[4], m_cnt[4], m_st[4], m_hit[4];
  bit m_kd[4];

  always @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (rst) begin
        m_px[k] = 0; m_py[k] = 0; m_vx[k] = 0; m_vy[k] = 0;
        m_cnt[k] = 0; m_st[k] = 0; m_hit[k] = 0; m_kd[k] = 0;
      end else begin
        bit rise, xl, xh, yl, yh;
        int px, vx, py, vy, nxt;
        rise = kick && !m_kd[k];
        m_kd[k] = kick;
        m_hit[k] = 0;
        if (kill) begin
          m_st[k] = 0; m_vx[k] = 0; m_vy[k] = 0;
        end else if (launch) begin
          m_px[k] = int'(lx) * 64;
          m_py[k] = int'(ly) * 64;
          m_vx[k] = clampi(int'($signed(lxs)));
          m_vy[k] = clampi(int'($signed(lys)));
          m_cnt[k] = 0;
          m_st[k] = (delay(k) == 0) ? 2 : 1;
        end else if (m_st[k] == 1) begin
          if (sof) begin
            m_cnt[k]++;
            if (m_cnt[k] == delay(k)) m_st[k] = 2;
          end
        end else if (m_st[k] == 2) begin
          nxt = pause ? 3 : 2;
          if (sof) begin
            axis(m_px[k] + m_vx[k], m_vx[k], XH, xmode(k), px, vx, xl, xh);
            axis(m_py[k] + m_vy[k], m_vy[k], YH, ymode(k), py, vy, yl, yh);
            if (rise && m_vy[k] > 0) vy = -m_vy[k];
            else if (!(yl || yh))   vy = clampi(m_vy[k] + 1);
            m_px[k] = px; m_vx[k] = vx; m_py[k] = py; m_vy[k] = vy;
            m_hit[k] = (yl ? 8 : 0) + (yh ? 4 : 0) + (xl ? 2 : 0) + (xh ? 1 : 0);
          end else if (rise && m_vy[k] > 0) begin
            m_vy[k] = -m_vy[k];
          end
          m_st[k] = nxt;
        end else if (m_st[k] == 3) begin
          if (!pause) m_st[k] = 2;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("u%0d.topLeftX", k), int'(o_tlx[k]), (m_px[k] >>> 6) & 2047);
        chk($sformatf("u%0d.topLeftY", k), int'(o_tly[k]), (m_py[k] >>> 6) & 2047);
        chk($sformatf("u%0d.active", k),   int'(o_act[k]), (m_st[k] >= 2) ? 1 : 0);
        chk($sformatf("u%0d.hitEdge", k),  int'(o_hit[k]), m_hit[k]);
        chk($sformatf("u%0d.state", k),    int'(o_st[k]),  m_st[k]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic frame();
    sof = 1'b1;
    tick();
    sof = 1'b0;
  endtask

  task automatic launch_it(input int x, input int y, input int xs, input int ys);
    lx = 11'(x); ly = 11'(y); lxs = 16'(xs); lys = 16'(ys);
    launch = 1'b1;
    tick();
    launch = 1'b0;
  endtask

  initial begin
    int exp_y[4];
    exp_y = '{7, 15, 23, 31};
    repeat (3) tick();
    chk_en = 1'b1;
    chk("reset_state", int'(o_st[0]), 0);
    chk("reset_topLeftX", int'(o_tlx[0]), 0);
    rst = 1'b0;
    tick();

    // Basic flight with gravity; variant 3 waits two frames before moving.
    launch_it(40, 100, 50, 0);
    chk("launch_state_u0", int'(o_st[0]), 2);
    chk("launch_active_u0", int'(o_act[0]), 1);
    chk("launch_state_u3", int'(o_st[3]), 1);
    for (int i = 0; i < 3; i++) begin
      frame();
      if (i == 0) chk("armed_after_f1_u3", int'(o_st[3]), 1);
      tick();
    end
    chk("flight_x_u0", int'(o_tlx[0]), 42);
    chk("flight_y_u0", int'(o_tly[0]), 100);
    chk("delayed_x_u3", int'(o_tlx[3]), 40);

    // Right edge bounce.
    launch_it(574, 100, 64, 0);
    frame();
    chk("bounce_x_u0", int'(o_tlx[0]), 575);
    chk("bounce_hit_u0", int'(o_hit[0]), 1);
    tick();
    chk("bounce_hit_clear_u0", int'(o_hit[0]), 0);
    frame();
    chk("bounce_back_u0", int'(o_tlx[0]), 574);
    tick();

    // Wrap (u1) and stop (u2) on the right edge.
    launch_it(575, 100, 64, 0);
    frame();
    chk("wrap_x_u1", int'(o_tlx[1]), 0);
    chk("wrap_hit_u1", int'(o_hit[1]), 1);
    chk("stop_x_u2", int'(o_tlx[2]), 575);
    tick();
    frame();
    chk("stop_hold_u2", int'(o_tlx[2]), 575);
    chk("wrap_move_u1", int'(o_tlx[1]), 1);
    tick();

    // Kick coinciding with a frame reverses a positive Y speed after the move.
    launch_it(100, 100, 0, 10);
    kick = 1'b1;
    frame();
    chk("kick_frame_y_u0", int'(o_tly[0]), 100);
    tick();
    frame(); tick();
    frame();
    chk("kick_reversed_y_u0", int'(o_tly[0]), 99);
    kick = 1'b0; tick();
    kick = 1'b1; tick();
    kick = 1'b0;
    frame(); tick();
    frame();
    chk("kick_ignored_y_u0", int'(o_tly[0]), 99);
    tick();

    // Pause freezes motion and ignores kicks.
    pause = 1'b1;
    tick();
    chk("paused_state_u0", int'(o_st[0]), 3);
    for (int i = 0; i < 5; i++) begin
      kick = (i == 1);
      frame();
      tick();
    end
    kick = 1'b0;
    chk("paused_x_u0", int'(o_tlx[0]), 100);
    chk("paused_y_u0", int'(o_tly[0]), 99);
    chk("paused_still_u0", int'(o_st[0]), 3);
    pause = 1'b0;
    tick();
    chk("resumed_state_u0", int'(o_st[0]), 2);

    // Kill beats a simultaneous launch.
    kill = 1'b1; launch = 1'b1;
    tick();
    kill = 1'b0; launch = 1'b0;
    chk("kill_state_u0", int'(o_st[0]), 0);
    chk("kill_active_u0", int'(o_act[0]), 0);
    chk("kill_hold_x_u0", int'(o_tlx[0]), 100);
    frame();
    chk("idle_no_motion_u0", int'(o_tly[0]), 99);
    tick();

    // Speed saturation, mid-frame kick, then a bounce off the top.
    launch_it(100, 0, 0, 510);
    for (int i = 0; i < 4; i++) begin
      frame();
      chk($sformatf("sat_y_f%0d_u0", i + 1), int'(o_tly[0]), exp_y[i]);
      tick();
    end
    kick = 1'b1; tick();
    kick = 1'b0;
    frame();
    chk("kick_mid_y_u0", int'(o_tly[0]), 23);
    tick();
    for (int i = 0; i < 4; i++) begin
      frame();
      if (i == 3) begin
        chk("top_bounce_y_u0", int'(o_tly[0]), 0);
        chk("top_bounce_hit_u0", int'(o_hit[0]), 8);
      end
      tick();
    end

    // Left bounce on frame 1, bottom bounce on frame 5.
    launch_it(1, 400, -100, 200);
    for (int i = 0; i < 5; i++) begin
      frame();
      if (i == 0) begin
        chk("left_hit_u0", int'(o_hit[0]), 2);
        chk("left_x_u0", int'(o_tlx[0]), 0);
      end
      if (i == 4) begin
        chk("bottom_hit_u0", int'(o_hit[0]), 4);
        chk("bottom_y_u0", int'(o_tly[0]), 415);
      end
      tick();
    end

    // Launch speeds beyond the limit are clamped.
    launch_it(200, 200, -1000, 1000);
    frame();
    chk("clamp_x_u0", int'(o_tlx[0]), 192);
    chk("clamp_y_u0", int'(o_tly[0]), 208);
    tick();

    // Synchronous reset mid-flight.
    frame();
    rst = 1'b1;
    tick();
    chk("rst_x_u0", int'(o_tlx[0]), 0);
    chk("rst_y_u0", int'(o_tly[0]), 0);
    chk("rst_state_u0", int'(o_st[0]), 0);
    chk("rst_active_u0", int'(o_act[0]), 0);
    chk("rst_hit_u0", int'(o_hit[0]), 0);
    rst = 1'b0;
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
